// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: byte stream in, little-endian words out,
// trailing 8-bit checksum, and core reset release once the image is good.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 32000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_run,
    output logic [15:0]           words_written
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StData, StWrite, StCsum, StDone, StErr
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic [15:0]           words_q, words_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        take;
    logic [7:0]  csum_next;
    logic [31:0] hdr_next;
    logic [31:0] asm_next;
    logic [15:0] words_inc;

    // Bytes shift in from the top so the first byte ends up as the LSB.
    assign take      = rx_valid && rx_ready;
    assign csum_next = csum_q + rx_data;
    assign hdr_next  = {rx_data, count_q[31:8]};
    assign asm_next  = {rx_data, asm_q[31:8]};
    assign words_inc = words_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            count_q    <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        words_d    = words_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHdr;
                    byte_cnt_d = '0;
                    count_d    = '0;
                    asm_d      = '0;
                    csum_d     = '0;
                    words_d    = '0;
                end
            end
            StHdr: begin
                if (take) begin
                    csum_d     = csum_next;
                    count_d    = hdr_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (hdr_next > 32'(MAX_WORDS)) begin
                            state_d = StErr;
                        end else if (hdr_next == 32'd0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (take) begin
                    csum_d     = csum_next;
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Latch the write port now so it is stable for the whole WRITE cycle.
                        state_d = StWrite;
                        wdata_d = asm_next;
                        addr_d  = ADDR_WIDTH'({words_q, 2'b00});
                    end
                end
            end
            StWrite: begin
                words_d = words_inc;
                state_d = ({16'd0, words_inc} == count_q) ? StCsum : StData;
            end
            StCsum: begin
                if (take) begin
                    csum_d  = csum_next;
                    state_d = (csum_next == 8'd0) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_ready      = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
        mem_we        = (state_q == StWrite);
        busy          = (state_q == StHdr) || (state_q == StData) ||
                        (state_q == StWrite) || (state_q == StCsum);
        done          = (state_q == StDone);
        error         = (state_q == StErr);
        cpu_run       = (state_q == StDone);
        words_written = words_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count reference model checked every cycle,
// directed images with literal expectations, then randomized images.
module tb_imem_loader;

    localparam int unsigned MAXW = 32000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_run;
    logic [15:0] words_written;

    imem_loader #(
        .ADDR_WIDTH(32),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_run      (cpu_run),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  img[$];
    int          busy_nr;

    // Model: mode 0 idle, 1 loading, 2 done, 3 error; k = bytes taken this load.
    int          m_mode;
    int          m_k;
    longint      m_n;
    logic [7:0]  m_sum;
    int          m_ww;
    bit          m_pend;
    logic [31:0] m_word;
    bit          e_busy, e_ready, e_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task model_reset();
        m_mode = 0; m_k = 0; m_n = 0; m_sum = 8'h00; m_ww = 0; m_pend = 1'b0; m_word = '0;
    endtask

    // Advance the model by one clock using the inputs that the next rising edge will see.
    task model_step();
        if (m_mode != 1) begin
            if (start) begin
                model_reset();
                m_mode = 1;
            end
        end else if (m_pend) begin
            m_pend = 1'b0;
            m_ww++;
        end else if (rx_valid) begin
            m_sum += rx_data;
            m_k++;
            if (m_k <= 4) begin
                m_n |= longint'(rx_data) << (8 * (m_k - 1));
                if (m_k == 4 && m_n > longint'(MAXW)) m_mode = 3;
            end else if (longint'(m_k) <= 4 + 4 * m_n) begin
                m_word[8*((m_k-5)%4) +: 8] = rx_data;
                if ((m_k - 4) % 4 == 0) m_pend = 1'b1;
            end else begin
                m_mode = (m_sum == 8'h00) ? 2 : 3;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        e_busy  = (m_mode == 1);
        e_ready = e_busy && !m_pend;
        e_we    = e_busy && m_pend;
        chk("rx_ready", 32'(rx_ready), 32'(e_ready));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("error", 32'(error), 32'(m_mode == 3));
        chk("cpu_run", 32'(cpu_run), 32'(m_mode == 2));
        chk("words_written", 32'(words_written), 32'(m_ww));
        if (e_we) begin
            chk("mem_addr", mem_addr, 32'(m_ww * 4));
            chk("mem_wdata", mem_wdata, m_word);
        end
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (busy === 1'b1 && rx_ready === 1'b0) busy_nr++;
        if (rst_n) model_step();
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
    endtask

    // Appends the byte that makes the 8-bit sum of the whole image zero, plus an optional skew.
    task automatic push_csum(input logic [7:0] skew);
        logic [7:0] s = 8'h00;
        foreach (img[i]) s += img[i];
        img.push_back(8'(8'h00 - s + skew));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte 0x%02h not taken, required within 40 cycles", b);
        end
    endtask

    task automatic send_image(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    rx_data = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            send_byte(img[i]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_ref_image(input logic [7:0] cs);
        img.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0000_006F);
        img.push_back(cs);
    endtask

    task automatic check_two_writes();
        chk("write_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            chk("write0_addr", log_addr[0], 32'h0);
            chk("write0_data", log_data[0], 32'h0000_0013);
            chk("write1_addr", log_addr[1], 32'h4);
            chk("write1_data", log_data[1], 32'h0000_006F);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint unsigned n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_cpu_run", 32'(cpu_run), 32'd0);
        rst_n = 1'b1;

        // Good two-word image: 0x02 + 0x13 + 0x6F + 0x7C = 0x100.
        load_ref_image(8'h7C);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(img.size(), 1'b0);
        settle();
        check_two_writes();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_run", 32'(cpu_run), 32'd1);
        chk("t1_words", 32'(words_written), 32'd2);

        // Bad checksum: words still land, load ends in error.
        load_ref_image(8'h7F);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(img.size(), 1'b0);
        settle();
        check_two_writes();
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_cpu_run", 32'(cpu_run), 32'd0);

        // N = 32001 is one over capacity.
        img.delete();
        push_word(32'h0000_7D01);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(4, 1'b0);
        settle();
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_writes", 32'(log_addr.size()), 32'd0);
        chk("t3_rx_ready", 32'(rx_ready), 32'd0);

        // Empty image.
        img.delete();
        push_word(32'd0);
        img.push_back(8'h00);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(img.size(), 1'b0);
        settle();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_words", 32'(words_written), 32'd0);
        chk("t4_writes", 32'(log_addr.size()), 32'd0);

        // One word with rx_valid held high throughout.
        img.delete();
        push_word(32'd1);
        push_word(32'hDEAD_BEEF);
        img.push_back(8'hC7);
        log_addr.delete(); log_data.delete();
        pulse_start();
        busy_nr = 0;
        send_image(img.size(), 1'b0);
        settle();
        chk("t5_ready_low_cycles", 32'(busy_nr), 32'd1);
        chk("t5_writes", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() >= 1) begin
            chk("t5_addr", log_addr[0], 32'h0);
            chk("t5_data", log_data[0], 32'hDEAD_BEEF);
        end
        chk("t5_done", 32'(done), 32'd1);

        // Reset after 6 data bytes of a two-word load.
        load_ref_image(8'h7C);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rx_ready", 32'(rx_ready), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_cpu_run", 32'(cpu_run), 32'd0);
        chk("t6_words", 32'(words_written), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_writes_before_reset", 32'(log_addr.size()), 32'd1);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_image(img.size(), 1'b0);
        settle();
        check_two_writes();
        chk("t6_done", 32'(done), 32'd1);

        // Randomized images, gaps and stray start pulses; the per-cycle model does the checking.
        repeat (16) begin
            img.delete();
            if ($urandom_range(0, 7) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 64'(MAXW + 1 + $urandom_range(0, 1000))
                                                : 64'h0000_0000_FFFF_FFFF;
                push_word(32'(n));
            end else begin
                n = 64'($urandom_range(0, 6));
                push_word(32'(n));
                for (int w = 0; w < int'(n); w++) push_word($urandom);
                push_csum(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
            pulse_start();
            send_image(img.size(), 1'b1);
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
